gabor_out_reader: RTL

- Read-back end of the Gabor convolution output path.
- The convolution engine writes one byte per pixel into four output BRAMs (45°, 90°, 135°, 180°) at a shared linear address.
- This block reads all four BRAMs in raster order at one shared address and emits each pixel's four orientation bytes as a single valid/ready stream beat, with row/frame markers, for host or display export.
- Handles the 1-cycle BRAM read latency and downstream backpressure without losing or duplicating pixels.

---
 rtl/gabor_out_reader.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/gabor_out_reader.sv
// Reads the four Gabor orientation BRAMs in raster order and streams one
// 4-byte beat per pixel with row/frame markers, absorbing BRAM latency and backpressure.
module gabor_out_reader #(
  parameter int IMAGE_WIDTH  = 512,
  parameter int IMAGE_HEIGHT = 512,
  parameter int IMAGE_SIZE   = 8,
  parameter int NUM_VALS     = 4,
  parameter int ADDR_WIDTH   = 18
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           bram_en,
  output logic [ADDR_WIDTH-1:0]          bram_addr,
  input  logic [NUM_VALS*IMAGE_SIZE-1:0] bram_dout,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [NUM_VALS*IMAGE_SIZE-1:0] m_data,
  output logic                           m_eol,
  output logic                           m_last
);

  localparam int DW    = NUM_VALS * IMAGE_SIZE;
  localparam int COL_W = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          eol;
    logic          last;
  } beat_t;

  state_t                state;
  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  in_flight;
  logic                  tag_eol;
  logic                  tag_last;

  beat_t                 fifo [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;

  logic                  pop;
  logic                  push;
  logic                  last_addr;
  logic [1:0]            count_after_pop;
  logic [1:0]            reserved;
  logic [1:0]            count_nxt;

  // NOTE: always_comb assigns every signal on every path, so no latch can be inferred.
  always_comb begin
    pop             = (count != 2'd0) && m_ready;
    push            = in_flight;
    last_addr       = (col == COL_LAST) && (row == ROW_LAST);
    count_after_pop = count - {1'b0, pop};
    // A read is only issued when its data is guaranteed a FIFO slot on landing.
    reserved        = count_after_pop + {1'b0, in_flight};
    bram_en         = (state == S_READ) && (reserved < 2'd2);
    count_nxt       = count_after_pop + {1'b0, push};
  end

  assign bram_addr = addr_q;
  assign m_valid   = (count != 2'd0);
  assign m_data    = fifo[rd_ptr].data;
  assign m_eol     = fifo[rd_ptr].eol;
  assign m_last    = fifo[rd_ptr].last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      col       <= '0;
      row       <= '0;
      addr_q    <= '0;
      in_flight <= 1'b0;
      tag_eol   <= 1'b0;
      tag_last  <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      // NOTE: the two buffer entries are reset so the head reads as zero after reset.
      fifo[0]   <= '0;
      fifo[1]   <= '0;
    end else begin
      in_flight <= bram_en;
      done      <= 1'b0;

      if (bram_en) begin
        tag_eol  <= (col == COL_LAST);
        tag_last <= last_addr;
        if (!last_addr) begin
          addr_q <= addr_q + ADDR_WIDTH'(1);
          if (col == COL_LAST) begin
            col <= '0;
            row <= row + ROW_W'(1);
          end else begin
            col <= col + COL_W'(1);
          end
        end
      end

      if (push) begin
        fifo[wr_ptr] <= '{data: bram_dout, eol: tag_eol, last: tag_last};
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count_nxt;

      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_READ;
            busy   <= 1'b1;
            col    <= '0;
            row    <= '0;
            addr_q <= '0;
          end
        end
        S_READ: begin
          if (bram_en && last_addr) state <= S_DRAIN;
        end
        S_DRAIN: begin
          // Finish in the same edge that pops the final beat.
          if (!in_flight && count_nxt == 2'd0) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
